// File: rtl/rd_dma_pkg.sv
// Shared types and constants for the read-DMA burst executor.
package rd_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_FIN  = 2'd3
    } rd_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AXI ARSIZE encoding for a full-width beat
    function automatic logic [2:0] beat_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi_read_burst_exec_if.sv
// Request handshake, AXI read channels and FIFO write port of the read-DMA burst executor.
interface axi_read_burst_exec_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int LSIZE      = 9
);
    logic                  fsync;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  burst_req;
    logic                  tail_req;
    logic [LSIZE-1:0]      req_len;
    logic                  resp;
    logic                  done;

    logic [ID_WIDTH-1:0]   axi_arid;
    logic [ADDR_WIDTH-1:0] axi_araddr;
    logic [7:0]            axi_arlen;
    logic [2:0]            axi_arsize;
    logic [1:0]            axi_arburst;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [DATA_WIDTH-1:0] axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rlast;
    logic                  axi_rvalid;
    logic                  axi_rready;

    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_wdata;
    logic                  fifo_full;
    logic                  is_tail;
    logic                  err;

    modport slave (
        input  fsync, base_addr, burst_req, tail_req, req_len,
               axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid, fifo_full,
        output resp, done, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
               axi_arvalid, axi_rready, fifo_wr_en, fifo_wdata, is_tail, err
    );

    modport master (
        output fsync, base_addr, burst_req, tail_req, req_len,
               axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid, fifo_full,
        input  resp, done, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
               axi_arvalid, axi_rready, fifo_wr_en, fifo_wdata, is_tail, err
    );

endinterface

// File: rtl/rd_beat_counter.sv
// Counts accepted R beats of one burst; flags the final beat and any rlast disagreement.
module rd_beat_counter #(
    parameter int LSIZE = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic [LSIZE-1:0] len_i,
    input  logic             beat_i,
    input  logic             rlast_i,
    output logic             last_beat_o,
    output logic             mismatch_o
);

    logic [LSIZE-1:0] cnt_q;
    logic [LSIZE-1:0] cnt_d;
    logic             at_last;

    always_comb begin
        at_last     = (cnt_q == len_i - LSIZE'(1));
        last_beat_o = beat_i && at_last;
        // covers both an early rlast and a missing rlast on the counted last beat
        mismatch_o  = beat_i && (rlast_i != at_last);
        cnt_d       = cnt_q;
        if (clr_i || last_beat_o) begin
            cnt_d = '0;
        end else if (beat_i) begin
            cnt_d = cnt_q + LSIZE'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi_read_burst_exec.sv
// Accepts one FIFO-status request at a time, issues a single AXI4 INCR read burst
// from a frame-relative running address and streams the R beats into the FIFO.
module axi_read_burst_exec
    import rd_dma_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 64,
    parameter int          ID_WIDTH   = 4,
    parameter int          LSIZE      = 9,
    parameter int unsigned ARID_VAL   = 0
) (
    input logic                  clock,
    input logic                  rst_n,
    axi_read_burst_exec_if.slave bus
);

    localparam logic [2:0] SIZE = beat_size(DATA_WIDTH);

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LSIZE-1:0]      len_q, len_d;
    logic                  is_tail_q, is_tail_d;
    logic                  err_q, err_d;
    logic                  resp_q, resp_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] pend_base_q, pend_base_d;

    logic req;
    logic rready;
    logic beat;
    logic last_beat;
    logic mismatch;

    assign req    = bus.burst_req | bus.tail_req;
    assign rready = (state_q == ST_DATA) && !bus.fifo_full;
    assign beat   = bus.axi_rvalid && rready;

    rd_beat_counter #(.LSIZE(LSIZE)) u_beat_counter (
        .clk_i       (clock),
        .rst_ni      (rst_n),
        .clr_i       (state_q == ST_IDLE),
        .len_i       (len_q),
        .beat_i      (beat),
        .rlast_i     (bus.axi_rlast),
        .last_beat_o (last_beat),
        .mismatch_o  (mismatch)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        is_tail_d   = is_tail_q;
        err_d       = err_q;
        resp_d      = 1'b0;
        pend_d      = pend_q;
        pend_base_d = pend_base_q;

        // a frame sync mid-burst is deferred so the burst in flight keeps its address
        if (bus.fsync && state_q != ST_IDLE) begin
            pend_d      = 1'b1;
            pend_base_d = bus.base_addr;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.fsync) begin
                    addr_d = bus.base_addr;
                    err_d  = 1'b0;
                end
                if (req) begin
                    resp_d    = 1'b1;
                    len_d     = bus.req_len;
                    is_tail_d = bus.tail_req & ~bus.burst_req;
                    state_d   = (bus.req_len != '0) ? ST_ADDR : ST_FIN;
                end
            end
            ST_ADDR: begin
                if (bus.axi_arready) begin
                    addr_d  = addr_q + (ADDR_WIDTH'(len_q) << SIZE);
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_beat) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
                if (bus.fsync) begin
                    addr_d = bus.base_addr;
                end else if (pend_q) begin
                    addr_d = pend_base_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (beat && (bus.axi_rresp != AXI_RESP_OKAY || mismatch)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            is_tail_q   <= 1'b0;
            err_q       <= 1'b0;
            resp_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_base_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            is_tail_q   <= is_tail_d;
            err_q       <= err_d;
            resp_q      <= resp_d;
            pend_q      <= pend_d;
            pend_base_q <= pend_base_d;
        end
    end

    assign bus.resp        = resp_q;
    assign bus.done        = (state_q == ST_FIN);
    assign bus.axi_arid    = ID_WIDTH'(ARID_VAL);
    assign bus.axi_araddr  = addr_q;
    assign bus.axi_arlen   = 8'(len_q - LSIZE'(1));
    assign bus.axi_arsize  = SIZE;
    assign bus.axi_arburst = AXI_BURST_INCR;
    assign bus.axi_arvalid = (state_q == ST_ADDR);
    assign bus.axi_rready  = rready;
    assign bus.fifo_wr_en  = beat;
    assign bus.fifo_wdata  = bus.axi_rdata;
    assign bus.is_tail     = is_tail_q;
    assign bus.err         = err_q;

endmodule
